// File: rtl/cnu_minsum_serial_if.sv
// Handshake bundle between a VNU array and one serial min-sum check node:
// variable-to-check messages in, check-to-variable messages out.
interface cnu_minsum_serial_if #(
    parameter int W  = 8,
    parameter int DC = 6
);
    localparam int IW = $clog2(DC);

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_msg;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_msg;
    logic [IW-1:0] out_idx;
    logic          parity;
    logic          cnu_over;

    modport master (
        output in_valid, in_msg, out_ready,
        input  in_ready, out_valid, out_msg, out_idx, parity, cnu_over
    );

    modport slave (
        input  in_valid, in_msg, out_ready,
        output in_ready, out_valid, out_msg, out_idx, parity, cnu_over
    );
endinterface

// File: rtl/cnu_minsum_serial.sv
// Serial offset-min-sum check node: collects DC messages, then emits DC
// extrinsic replies in arrival order, one per output handshake.
module cnu_minsum_serial #(
    parameter int W      = 8,
    parameter int DC     = 6,
    parameter int OFFSET = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    cnu_minsum_serial_if.slave     bus
);
    localparam int            IW        = $clog2(DC);
    localparam logic [W-2:0]  MAG_MAX   = {(W-1){1'b1}};
    localparam logic [W-2:0]  MAG_ZERO  = {(W-1){1'b0}};
    localparam logic [W-2:0]  MAG_ONE   = (W-1)'(1);
    localparam logic [W-2:0]  OFF_C     = (W-1)'(OFFSET);
    localparam logic [W-1:0]  WORD_ONE  = W'(1);
    localparam logic [W-1:0]  WORD_ZERO = W'(0);
    localparam logic [IW-1:0] IDX_ZERO  = IW'(0);
    localparam logic [IW-1:0] IDX_ONE   = IW'(1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DC - 1);
    localparam logic [DC-1:0] SIGNS_CLR = {DC{1'b0}};

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

    // |msg| with the most negative code saturated to the largest magnitude
    function automatic logic [W-2:0] sat_mag(input logic [W-1:0] msg);
        logic [W-2:0] r;
        if (msg[W-1] == 1'b0) begin
            r = msg[W-2:0];
        end else if (msg[W-2:0] == MAG_ZERO) begin
            r = MAG_MAX;
        end else begin
            r = ~msg[W-2:0] + MAG_ONE;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] c2v_msg(input logic [W-2:0] m, input logic neg);
        logic [W-2:0] mp;
        logic [W-1:0] r;
        if (m > OFF_C) begin
            mp = m - OFF_C;
        end else begin
            mp = MAG_ZERO;
        end
        r = {1'b0, mp};
        if (neg) begin
            r = ~r + WORD_ONE;
        end else begin
            r = {1'b0, mp};
        end
        return r;
    endfunction

    state_t        state_q, state_d;
    logic [IW-1:0] in_cnt_q, in_cnt_d;
    logic [W-2:0]  min1_q, min1_d;
    logic [W-2:0]  min2_q, min2_d;
    logic [IW-1:0] min1_idx_q, min1_idx_d;
    logic [DC-1:0] signs_q, signs_d;
    logic          sign_total_q, sign_total_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_msg_q, out_msg_d;
    logic [IW-1:0] out_idx_q, out_idx_d;
    logic          parity_q, parity_d;
    logic          cnu_over_q, cnu_over_d;

    logic          in_fire_s;
    logic          out_fire_s;
    logic [W-2:0]  in_mag_s;
    logic [IW-1:0] emit_sel_s;
    logic [W-2:0]  emit_mag_s;
    logic          emit_neg_s;
    logic [W-1:0]  emit_msg_s;

    // Reply for the edge about to be presented: idx 0 on entry, else the next one
    always_comb begin
        in_fire_s  = in_ready_q & bus.in_valid;
        out_fire_s = out_valid_q & bus.out_ready;
        in_mag_s   = sat_mag(bus.in_msg);
        if (out_valid_q) begin
            emit_sel_s = out_idx_q + IDX_ONE;
        end else begin
            emit_sel_s = IDX_ZERO;
        end
        if (emit_sel_s == min1_idx_q) begin
            emit_mag_s = min2_q;
        end else begin
            emit_mag_s = min1_q;
        end
        emit_neg_s = sign_total_q ^ signs_q[emit_sel_s];
        emit_msg_s = c2v_msg(emit_mag_s, emit_neg_s);
    end

    // Next-state and registered-output computation for the COLLECT/EMIT FSM
    always_comb begin
        state_d      = state_q;
        in_cnt_d     = in_cnt_q;
        min1_d       = min1_q;
        min2_d       = min2_q;
        min1_idx_d   = min1_idx_q;
        signs_d      = signs_q;
        sign_total_d = sign_total_q;
        in_ready_d   = in_ready_q;
        out_valid_d  = out_valid_q;
        out_msg_d    = out_msg_q;
        out_idx_d    = out_idx_q;
        parity_d     = parity_q;
        cnu_over_d   = 1'b0;
        case (state_q)
            COLLECT: begin
                if (in_fire_s) begin
                    signs_d[in_cnt_q] = bus.in_msg[W-1];
                    sign_total_d      = sign_total_q ^ bus.in_msg[W-1];
                    // Strict compares keep the first occurrence on ties
                    if (in_mag_s < min1_q) begin
                        min2_d     = min1_q;
                        min1_d     = in_mag_s;
                        min1_idx_d = in_cnt_q;
                    end else if (in_mag_s < min2_q) begin
                        min2_d = in_mag_s;
                    end else begin
                        min2_d = min2_q;
                    end
                    if (in_cnt_q == IDX_LAST) begin
                        state_d    = EMIT;
                        in_ready_d = 1'b0;
                        in_cnt_d   = IDX_ZERO;
                    end else begin
                        in_cnt_d = in_cnt_q + IDX_ONE;
                    end
                end else begin
                    in_cnt_d = in_cnt_q;
                end
            end
            EMIT: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_idx_d   = emit_sel_s;
                    out_msg_d   = emit_msg_s;
                end else if (out_fire_s) begin
                    if (out_idx_q == IDX_LAST) begin
                        state_d      = COLLECT;
                        out_valid_d  = 1'b0;
                        in_ready_d   = 1'b1;
                        cnu_over_d   = 1'b1;
                        parity_d     = sign_total_q;
                        out_idx_d    = IDX_ZERO;
                        in_cnt_d     = IDX_ZERO;
                        min1_d       = MAG_MAX;
                        min2_d       = MAG_MAX;
                        min1_idx_d   = IDX_ZERO;
                        signs_d      = SIGNS_CLR;
                        sign_total_d = 1'b0;
                    end else begin
                        out_idx_d = emit_sel_s;
                        out_msg_d = emit_msg_s;
                    end
                end else begin
                    out_msg_d = out_msg_q;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // State register; reset discards any partial update
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= COLLECT;
            in_cnt_q     <= IDX_ZERO;
            min1_q       <= MAG_MAX;
            min2_q       <= MAG_MAX;
            min1_idx_q   <= IDX_ZERO;
            signs_q      <= SIGNS_CLR;
            sign_total_q <= 1'b0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_msg_q    <= WORD_ZERO;
            out_idx_q    <= IDX_ZERO;
            parity_q     <= 1'b0;
            cnu_over_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_cnt_q     <= in_cnt_d;
            min1_q       <= min1_d;
            min2_q       <= min2_d;
            min1_idx_q   <= min1_idx_d;
            signs_q      <= signs_d;
            sign_total_q <= sign_total_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_msg_q    <= out_msg_d;
            out_idx_q    <= out_idx_d;
            parity_q     <= parity_d;
            cnu_over_q   <= cnu_over_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_msg   = out_msg_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.parity    = parity_q;
    assign bus.cnu_over  = cnu_over_q;
endmodule

// File: tb/tb_cnu_minsum_serial.sv
// Directed bench: two lockstep check nodes (OFFSET 0 and 1) driven by one stimulus.
module tb_cnu_minsum_serial;
    typedef int vec_t [6];

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_msg;
    logic       out_ready;
    int         n_assert;
    int         n_fail;

    cnu_minsum_serial_if #(.W(8), .DC(6)) bus0 ();
    cnu_minsum_serial_if #(.W(8), .DC(6)) bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.in_msg    = in_msg;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.in_msg    = in_msg;
    assign bus1.out_ready = out_ready;

    cnu_minsum_serial #(.W(8), .DC(6), .OFFSET(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    cnu_minsum_serial #(.W(8), .DC(6), .OFFSET(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input int expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic run_vec(input vec_t v, input vec_t e0, input vec_t e1, input bit chk1,
                           input int par, input int stall, input bit gap, input bit junk);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_msg   = 8'(v[i]);
            @(negedge clk);
            if (gap && i == 2) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
        in_valid = junk;
        in_msg   = 8'hFF;
        chk("latency_valid", bus0.out_valid, 0);
        chk("emit_in_ready", bus0.in_ready, 0);
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("valid%0d", i), bus0.out_valid, 1);
            chk($sformatf("idx%0d", i), bus0.out_idx, i);
            chk($sformatf("msg%0d", i), $signed(bus0.out_msg), e0[i]);
            chk($sformatf("over_low%0d", i), bus0.cnu_over, 0);
            if (chk1) begin
                chk($sformatf("off_msg%0d", i), $signed(bus1.out_msg), e1[i]);
            end
            if (i == stall) begin
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_valid", bus0.out_valid, 1);
                    chk("stall_idx", bus0.out_idx, i);
                    chk("stall_msg", $signed(bus0.out_msg), e0[i]);
                    chk("stall_in_ready", bus0.in_ready, 0);
                end
                out_ready = 1'b1;
            end
            if (i == 5) begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("over_pulse", bus0.cnu_over, 1);
        chk("parity", bus0.parity, par);
        chk("done_in_ready", bus0.in_ready, 1);
        chk("done_valid", bus0.out_valid, 0);
        if (chk1) begin
            chk("off_over", bus1.cnu_over, 1);
        end
        @(negedge clk);
        chk("over_once", bus0.cnu_over, 0);
    endtask

    initial begin
        vec_t basic_v, basic_e, off_e, sat_v, sat_e, tie_v, tie_e;
        basic_v = '{5, -3, 7, 2, -9, 4};
        basic_e = '{2, -2, 2, 3, -2, 2};
        off_e   = '{1, -1, 1, 2, -1, 1};
        sat_v   = '{-128, 10, 20, 30, 40, 50};
        sat_e   = '{10, -20, -10, -10, -10, -10};
        tie_v   = '{4, 4, 9, 9, 9, 9};
        tie_e   = '{4, 4, 4, 4, 4, 4};
        n_assert  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_msg    = 8'h00;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus0.in_ready, 1);
        chk("rst_out_valid", bus0.out_valid, 0);
        chk("rst_out_msg", bus0.out_msg, 0);
        chk("rst_out_idx", bus0.out_idx, 0);
        chk("rst_parity", bus0.parity, 0);
        chk("rst_over", bus0.cnu_over, 0);
        rst = 1'b0;
        @(negedge clk);

        run_vec(basic_v, basic_e, off_e, 1'b1, 0, -1, 1'b0, 1'b0);
        run_vec(sat_v, sat_e, off_e, 1'b0, 1, -1, 1'b0, 1'b1);
        run_vec(tie_v, tie_e, off_e, 1'b0, 0, -1, 1'b1, 1'b0);
        run_vec(basic_v, basic_e, off_e, 1'b1, 0, 2, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_msg   = 8'(sat_v[i]);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", bus0.in_ready, 1);
        chk("midrst_out_valid", bus0.out_valid, 0);
        rst = 1'b0;
        run_vec(basic_v, basic_e, off_e, 1'b1, 0, -1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/cnu_minsum_serial.md
CNU_MINSUM_SERIAL -- requirements
Module: cnu_minsum_serial

Interface
REQ-001 SHALL have parameter W, default 8: message width, two's complement; matches the VNU message width.
REQ-002 SHALL have parameter DC, default 6: check-node degree, range 2..16.
REQ-003 SHALL have parameter OFFSET, default 0: offset-min-sum magnitude correction, range 0..2^(W-1)-1.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1: in_msg carries a variable-to-check message.
REQ-007 SHALL have port in_ready  output  1: block accepts a message this cycle.
REQ-008 SHALL have port in_msg  input  W: variable-to-check message, taken from a VNU msg_to_check output.
REQ-009 SHALL have port out_valid  output  1: out_msg/out_idx hold a check-to-variable message.
REQ-010 SHALL have port out_ready  input  1: downstream consumes the output this cycle.
REQ-011 SHALL have port out_msg  output  W: check-to-variable message, routed to a VNU msg_from_check input.
REQ-012 SHALL have port out_idx  output  clog2(DC): edge index of out_msg (0..DC-1, arrival order).
REQ-013 SHALL have port parity  output  1: XOR of input sign bits; valid while cnu_over=1.
REQ-014 SHALL have port cnu_over  output  1: one-cycle pulse on the handshake of the last output.

Function
REQ-015 SHALL implement two states: COLLECT and EMIT.
REQ-016 SHALL, in COLLECT, drive in_ready=1 and out_valid=0, and accept in_msg on each cycle with in_valid=1.
REQ-017 SHALL hold all state when in_valid=0 in COLLECT; idle cycles are allowed between messages.
REQ-018 SHALL count accepted messages in the edge counter; on the DC-th accept, go to EMIT on the next cycle.
REQ-019 SHALL compute, per accepted message, sign = msg[W-1] and mag = |msg|, saturating -2^(W-1) to 2^(W-1)-1.
REQ-020 SHALL track min1, min2 and min1_idx: mag < min1 moves min1 to min2 and loads min1/min1_idx; else mag < min2 loads min2. Comparisons SHALL be strict, so on a tie min1_idx is the first occurrence and min2 equals min1.
REQ-021 SHALL store the DC sign bits in a register vector and accumulate their XOR as sign_total.
REQ-022 SHALL initialise min1 and min2 to 2^(W-1)-1 at the start of each check-node update.
REQ-023 SHALL, in EMIT, drive in_ready=0 and out_valid=1, with out_idx = emit counter starting at 0.
REQ-024 SHALL select the output magnitude as m = (out_idx==min1_idx) ? min2 : min1, then m' = max(m-OFFSET, 0).
REQ-025 SHALL drive out_msg = sign_total XOR sign[out_idx] ? -m' : +m' (negative zero is 0).
REQ-026 SHALL hold out_msg and out_idx stable while out_valid=1 and out_ready=0, and SHALL advance the emit counter only on out_valid&out_ready.
REQ-027 SHALL, on the handshake with out_idx=DC-1, pulse cnu_over=1 with parity=sign_total, and return to COLLECT on the next cycle with counters cleared and min1/min2 reinitialised.
REQ-028 SHALL have an output latency of one cycle: if the DC-th input is accepted at edge N, out_valid=1 with out_idx=0 after edge N+1.
REQ-029 SHALL NOT overlap two updates; in_valid during EMIT is ignored.
REQ-030 SHALL register out_msg, out_idx, out_valid, in_ready, parity and cnu_over.

Reset
REQ-031 SHALL, on rst=1 at a clock edge, enter COLLECT and set: counters=0, min1=min2=2^(W-1)-1, min1_idx=0, signs=0, sign_total=0, in_ready=1, out_valid=0, out_msg=0, out_idx=0, parity=0, cnu_over=0.
REQ-032 SHALL give rst priority over any simultaneous handshake, including mid-COLLECT and mid-EMIT; partial data SHALL be discarded.

Verification
REQ-033 SHALL pass the basic case (DC=6, OFFSET=0): inputs 5,-3,7,2,-9,4 -> outputs idx0..5 = +2,-2,+2,+3,-2,+2; parity=0; cnu_over pulses once.
REQ-034 SHALL pass saturation: inputs -128,10,20,30,40,50 -> outputs +10,-20,-10,-10,-10,-10; parity=1.
REQ-035 SHALL pass the tie case: inputs 4,4,9,9,9,9 -> all six outputs +4.
REQ-036 SHALL pass backpressure: on the REQ-033 vector, hold out_ready=0 for 3 cycles at idx2 -> out_msg=+2 and out_idx=2 held, in_ready=0, no skipped or duplicated index.
REQ-037 SHALL pass reset mid-operation: assert rst after 3 inputs -> in_ready=1 and out_valid=0 next cycle; then send the REQ-033 vector -> the REQ-033 outputs exactly.
REQ-038 SHALL pass the offset case: OFFSET=1 with the REQ-033 vector -> +1,-1,+1,+2,-1,+1.
